eth_tx_arbiter: RTL and testbench

Frame-level arbiter that shares the single GMII transmit path between several frame sources, for example the ARP responder and the TRDP/UDP transmitter. It sits upstream of gmii2rgmii in the gmii_tx_clk domain.
- Grants one requester at a time using round-robin.
- Forwards that requester's byte stream and enforces the inter-frame gap (IFG).
- Guards against stalled and runaway requesters.
- Lets the speed-adaptation logic freeze new grants during a link speed change.

---
 rtl/eth_tx_arb_pkg.sv | 25 ++
 rtl/eth_rr_picker.sv | 35 +++
 rtl/eth_tx_arbiter.sv | 167 ++++++++++++++++
 tb/tb_eth_tx_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_arb_pkg.sv
// eth_tx_arb_pkg: shared state type, frame defaults and small helpers
// for the GMII transmit arbiter and its round-robin picker.
package eth_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    XMIT,
    IFG
  } arb_state_t;

  localparam int ETH_IFG_DEFAULT       = 12;
  localparam int ETH_MAX_FRAME_DEFAULT = 1522;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // 16-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/eth_rr_picker.sv
// eth_rr_picker: combinational round-robin picker. Scans req starting one
// past last_grant, wrapping, and returns the first set bit as a one-hot
// pick, its index and a valid flag. Shared with the RX buffer arbiter.
module eth_rr_picker
  import eth_tx_arb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               pick_valid
);

  logic [IDX_W-1:0] cand_idx;

  // Walk the requesters in rotating priority order; the first hit wins.
  always_comb begin
    pick       = '0;
    pick_idx   = '0;
    pick_valid = 1'b0;
    cand_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_idx = IDX_W'((int'(last_grant) + 1 + i) % NUM_REQ);
      if (!pick_valid && req[cand_idx]) begin
        pick_valid     = 1'b1;
        pick_idx       = cand_idx;
        pick[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: frame-level round-robin arbiter sharing one GMII TX path
// between several frame sources. Forwards the granted byte stream with one
// cycle of latency, enforces the inter-frame gap, times out requesters that
// never start and cuts frames that run past the maximum length.
// Optional build macro TX_ARB_STATS_EN adds per-requester completed-frame
// counters and a combined abort/timeout counter.
module eth_tx_arbiter
  import eth_tx_arb_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int IFG_CYCLES      = ETH_IFG_DEFAULT,
  parameter int START_TIMEOUT   = 16,
  parameter int MAX_FRAME_BYTES = ETH_MAX_FRAME_DEFAULT
) (
  input  logic                 gmii_tx_clk,
  input  logic                 gmii_tx_rst,
  input  logic                 arb_hold,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   grant,
  input  logic [NUM_REQ-1:0]   src_tx_en,
  input  logic [NUM_REQ*8-1:0] src_txd,
  output logic                 gmii_tx_en,
  output logic [7:0]           gmii_txd,
  output logic                 arb_busy,
  output logic                 start_timeout_err,
  output logic                 frame_abort
`ifdef TX_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0] frame_cnt,
  output logic [15:0]           abort_cnt
`endif
);

  localparam int IDX_W  = idx_width(NUM_REQ);
  localparam int TO_W   = $clog2(START_TIMEOUT + 1);
  localparam int IFG_W  = $clog2(IFG_CYCLES + 1);
  localparam int BYTE_W = $clog2(MAX_FRAME_BYTES + 1);

  localparam logic [IDX_W-1:0]  LAST_INIT = IDX_W'(NUM_REQ - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(START_TIMEOUT - 1);
  localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(START_TIMEOUT);
  localparam logic [IFG_W-1:0]  IFG_LAST  = IFG_W'(IFG_CYCLES - 1);
  localparam logic [BYTE_W-1:0] BYTE_MAX  = BYTE_W'(MAX_FRAME_BYTES);

  arb_state_t        state;
  logic [IDX_W-1:0]  last_grant;
  logic [TO_W-1:0]   timer;
  logic [IFG_W-1:0]  ifg_cnt;
  logic [BYTE_W-1:0] byte_cnt;

  logic [NUM_REQ-1:0] pick;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;

  // last_grant doubles as the index of the current owner once granted,
  // so the source mux needs no separate select register.
  logic       gnt_req;
  logic       gnt_tx_en;
  logic [7:0] gnt_txd;

  assign gnt_req   = req[last_grant];
  assign gnt_tx_en = src_tx_en[last_grant];
  assign gnt_txd   = src_txd[{last_grant, 3'b000} +: 8];
  assign arb_busy  = (state != IDLE);

  eth_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req        (req),
    .last_grant (last_grant),
    .pick       (pick),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

  // Arbitration FSM; every output is registered here so the GMII side sees
  // a clean one-cycle pipeline and the error flags are single-cycle pulses.
  always_ff @(posedge gmii_tx_clk) begin
    if (gmii_tx_rst) begin
      state             <= IDLE;
      grant             <= '0;
      gmii_tx_en        <= 1'b0;
      gmii_txd          <= '0;
      start_timeout_err <= 1'b0;
      frame_abort       <= 1'b0;
      last_grant        <= LAST_INIT;
      timer             <= '0;
      ifg_cnt           <= '0;
      byte_cnt          <= '0;
`ifdef TX_ARB_STATS_EN
      frame_cnt         <= '0;
      abort_cnt         <= '0;
`endif
    end else begin
      start_timeout_err <= 1'b0;
      frame_abort       <= 1'b0;
      gmii_tx_en        <= 1'b0;
      gmii_txd          <= '0;
      case (state)
        IDLE: begin
          if (!arb_hold && pick_valid) begin
            grant      <= pick;
            last_grant <= pick_idx;
            timer      <= '0;
            state      <= GRANT;
          end
        end
        GRANT: begin
          if (gnt_tx_en) begin
            gmii_tx_en <= 1'b1;
            gmii_txd   <= gnt_txd;
            byte_cnt   <= BYTE_W'(1);
            state      <= XMIT;
          end else if (!gnt_req) begin
            grant <= '0;
            state <= IDLE;
          end else if (timer == TO_LAST) begin
            grant             <= '0;
            start_timeout_err <= 1'b1;
            ifg_cnt           <= '0;
            state             <= IFG;
`ifdef TX_ARB_STATS_EN
            abort_cnt         <= sat_inc16(abort_cnt);
`endif
          end else if (timer != TO_MAX) begin
            timer <= timer + 1'b1;
          end
        end
        XMIT: begin
          if (!gnt_tx_en) begin
            grant   <= '0;
            ifg_cnt <= '0;
            state   <= IFG;
`ifdef TX_ARB_STATS_EN
            frame_cnt[{last_grant, 4'b0000} +: 16] <=
              sat_inc16(frame_cnt[{last_grant, 4'b0000} +: 16]);
`endif
          end else if (byte_cnt >= BYTE_MAX) begin
            frame_abort <= 1'b1;
            grant       <= '0;
            ifg_cnt     <= '0;
            state       <= IFG;
`ifdef TX_ARB_STATS_EN
            abort_cnt   <= sat_inc16(abort_cnt);
`endif
          end else begin
            gmii_tx_en <= 1'b1;
            gmii_txd   <= gnt_txd;
            byte_cnt   <= byte_cnt + 1'b1;
          end
        end
        IFG: begin
          if (ifg_cnt >= IFG_LAST) begin
            state <= IDLE;
          end else begin
            ifg_cnt <= ifg_cnt + 1'b1;
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter: directed self-checking bench for eth_tx_arbiter with
// default parameters (2 requesters, IFG 12, start timeout 16, 1522 bytes).
// Inputs change and outputs are sampled on the falling clock edge.
// With TX_ARB_STATS_EN defined the statistics counters are also checked.
module tb_eth_tx_arbiter;

  logic        gmii_tx_clk = 1'b0;
  logic        gmii_tx_rst = 1'b1;
  logic        arb_hold    = 1'b0;
  logic [1:0]  req         = '0;
  logic [1:0]  src_tx_en   = '0;
  logic [15:0] src_txd     = '0;
  logic [1:0]  grant;
  logic        gmii_tx_en;
  logic [7:0]  gmii_txd;
  logic        arb_busy;
  logic        start_timeout_err;
  logic        frame_abort;
`ifdef TX_ARB_STATS_EN
  logic [31:0] frame_cnt;
  logic [15:0] abort_cnt;
`endif

  int   checks   = 0;
  int   passes   = 0;
  int   zero_run = 0;
  int   last_gap = 0;
  logic prev_en  = 1'b0;

  always #5 gmii_tx_clk = ~gmii_tx_clk;

  eth_tx_arbiter dut (
    .gmii_tx_clk       (gmii_tx_clk),
    .gmii_tx_rst       (gmii_tx_rst),
    .arb_hold          (arb_hold),
    .req               (req),
    .grant             (grant),
    .src_tx_en         (src_tx_en),
    .src_txd           (src_txd),
    .gmii_tx_en        (gmii_tx_en),
    .gmii_txd          (gmii_txd),
    .arb_busy          (arb_busy),
    .start_timeout_err (start_timeout_err),
    .frame_abort       (frame_abort)
`ifdef TX_ARB_STATS_EN
    ,
    .frame_cnt         (frame_cnt),
    .abort_cnt         (abort_cnt)
`endif
  );

  // Counts every comparison and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Drives one source's byte lane.
  task automatic applyStimulus(input int idx, input logic en, input logic [7:0] d);
    src_tx_en[idx]       = en;
    src_txd[idx*8 +: 8]  = d;
  endtask

  // Advances to the next falling edge and tracks runs of gmii_tx_en=0.
  task automatic tick();
    @(negedge gmii_tx_clk);
    if (gmii_tx_en === 1'b1) begin
      if (!prev_en) last_gap = zero_run;
      zero_run = 0;
      prev_en  = 1'b1;
    end else begin
      zero_run++;
      prev_en = 1'b0;
    end
  endtask

  // Waits (bounded) for any grant and checks that it is the expected one.
  task automatic waitGrant(input logic [1:0] exp, input string tag, output int n);
    n = 0;
    while (grant === 2'b00 && n < 64) begin
      tick();
      n++;
    end
    checkOutput(tag, grant, exp);
  endtask

  // Requests, waits for the grant and sends len bytes base, base+1, ...
  task automatic sendFrame(input int idx, input int len, input logic [7:0] base,
                           input logic drop_req, input int exp_lat, input int exp_gap);
    int n;
    logic [7:0] b;
    req[idx] = 1'b1;
    waitGrant(2'(1 << idx), "frame_grant", n);
    if (exp_lat >= 0) checkOutput("grant_latency", n, exp_lat);
    for (int k = 0; k < len; k++) begin
      b = base + 8'(k);
      applyStimulus(idx, 1'b1, b);
      tick();
      checkOutput("frame_en", gmii_tx_en, 1);
      checkOutput("frame_txd", gmii_txd, b);
      if (k == 0 && exp_gap >= 0) checkOutput("frame_gap", last_gap, exp_gap);
    end
    applyStimulus(idx, 1'b0, 8'h00);
    if (drop_req) req[idx] = 1'b0;
    tick();
    checkOutput("frame_end_en", gmii_tx_en, 0);
    checkOutput("frame_end_grant", grant, 0);
  endtask

  // Source 0 holds tx_en for 2000 bytes; only 1522 may be forwarded.
  task automatic runawayFrame();
    int n;
    int fwd = 0;
    int derr = 0;
    int aborts = 0;
    int abort_at = -1;
    logic [1:0] grant_at_abort = 2'b11;
    req[0] = 1'b1;
    waitGrant(2'b01, "run_grant", n);
    for (int k = 0; k < 2000; k++) begin
      applyStimulus(0, 1'b1, 8'(k));
      tick();
      if (gmii_tx_en === 1'b1) begin
        fwd++;
        if (gmii_txd !== 8'(k)) derr++;
      end
      if (frame_abort === 1'b1) begin
        aborts++;
        abort_at       = k;
        grant_at_abort = grant;
        req[0]         = 1'b0;
      end
    end
    applyStimulus(0, 1'b0, 8'h00);
    tick();
    checkOutput("run_fwd_bytes", fwd, 1522);
    checkOutput("run_data_err", derr, 0);
    checkOutput("run_abort_pulses", aborts, 1);
    checkOutput("run_abort_at", abort_at, 1522);
    checkOutput("run_grant_cleared", grant_at_abort, 0);
    checkOutput("run_idle_after", arb_busy, 0);
  endtask

  initial begin
    int n;
    int cnt;
    int errs;

    // Reset values
    repeat (3) tick();
    checkOutput("rst_grant", grant, 0);
    checkOutput("rst_tx_en", gmii_tx_en, 0);
    checkOutput("rst_txd", gmii_txd, 0);
    checkOutput("rst_busy", arb_busy, 0);
    checkOutput("rst_to_err", start_timeout_err, 0);
    checkOutput("rst_abort", frame_abort, 0);
    gmii_tx_rst = 1'b0;
    tick();
    checkOutput("post_rst_busy", arb_busy, 0);

    // Single 64-byte frame on source 0, then the busy tail of the IFG
    $display("[TB] single frame");
    sendFrame(0, 64, 8'h00, 1'b1, 1, -1);
    checkOutput("ifg_busy_start", arb_busy, 1);
    n = 0;
    while (arb_busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checkOutput("ifg_busy_len", n, 12);

    // Round robin from a fresh reset: order 0,1,0,1 with a 14-cycle gap
    $display("[TB] round robin");
    gmii_tx_rst = 1'b1;
    tick();
    gmii_tx_rst = 1'b0;
    req = 2'b11;
    for (int f = 0; f < 4; f++) begin
      sendFrame(f % 2, 60, 8'(f * 16 + 8'h40), (f >= 2), -1, (f > 0) ? 14 : -1);
    end
    repeat (14) tick();

    // Start timeout on source 1, regrant after IFG, then req drop in GRANT
    $display("[TB] start timeout");
    req = 2'b10;
    waitGrant(2'b10, "to_grant", n);
    n = 0;
    do begin
      tick();
      n++;
    end while (start_timeout_err !== 1'b1 && n < 40);
    checkOutput("to_delay", n, 16);
    checkOutput("to_grant_clr", grant, 0);
    checkOutput("to_busy", arb_busy, 1);
    n = 0;
    errs = 0;
    do begin
      tick();
      n++;
      if (start_timeout_err === 1'b1) errs++;
    end while (grant === 2'b00 && n < 40);
    checkOutput("to_regrant_delay", n, 13);
    checkOutput("to_single_pulse", errs, 0);
    checkOutput("to_regrant", grant, 2'b10);
    req = 2'b00;
    tick();
    checkOutput("drop_grant", grant, 0);
    checkOutput("drop_busy", arb_busy, 0);
    checkOutput("drop_no_err", start_timeout_err, 0);

    // Runaway frame
    $display("[TB] runaway frame");
    runawayFrame();

    // Hold raised mid-frame: frame completes, no new grant while held
    $display("[TB] arb_hold");
    req = 2'b01;
    waitGrant(2'b01, "hold_grant", n);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 5) begin
        arb_hold = 1'b1;
        req[1]   = 1'b1;
      end
      applyStimulus(0, 1'b1, 8'h10 + 8'(k));
      tick();
      if (gmii_tx_en === 1'b1 && gmii_txd === 8'h10 + 8'(k)) cnt++;
    end
    applyStimulus(0, 1'b0, 8'h00);
    req[0] = 1'b0;
    tick();
    checkOutput("hold_frame_bytes", cnt, 20);
    checkOutput("hold_frame_end", gmii_tx_en, 0);
    cnt = 0;
    repeat (30) begin
      tick();
      if (grant !== 2'b00) cnt++;
    end
    checkOutput("hold_no_grant", cnt, 0);
    checkOutput("hold_idle", arb_busy, 0);
    arb_hold = 1'b0;
    waitGrant(2'b10, "hold_release", n);
    checkOutput("hold_release_lat", n, 1);
    req = 2'b00;
    tick();
    checkOutput("hold_release_drop", grant, 0);

    // Reset pulsed mid-frame
    $display("[TB] reset mid-frame");
    req = 2'b10;
    waitGrant(2'b10, "rst_mid_grant", n);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1, 1'b1, 8'hA0 + 8'(k));
      tick();
    end
    checkOutput("rst_mid_pre_en", gmii_tx_en, 1);
    gmii_tx_rst = 1'b1;
    tick();
    checkOutput("rst_mid_en", gmii_tx_en, 0);
    checkOutput("rst_mid_grant", grant, 0);
    checkOutput("rst_mid_busy", arb_busy, 0);
    gmii_tx_rst = 1'b0;
    applyStimulus(1, 1'b0, 8'h00);
    req = 2'b00;
    tick();
    checkOutput("rst_mid_after", gmii_tx_en, 0);

`ifdef TX_ARB_STATS_EN
    // Statistics: three normal frames on source 1 plus one abort
    $display("[TB] statistics");
    checkOutput("stats_rst_frames", frame_cnt, 0);
    checkOutput("stats_rst_aborts", abort_cnt, 0);
    for (int f = 0; f < 3; f++) sendFrame(1, 8, 8'h20, 1'b1, -1, -1);
    runawayFrame();
    checkOutput("stats_frames_src1", frame_cnt[31:16], 3);
    checkOutput("stats_frames_src0", frame_cnt[15:0], 0);
    checkOutput("stats_aborts", abort_cnt, 1);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
